// File: rtl/vga_sync_monitor_if.sv
// +------------------------------------------------------------------+
// | vga_sync_monitor_if                                              |
// | Sync inputs and recovered-timing outputs of vga_sync_monitor.    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

interface vga_sync_monitor_if #(
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 525
);
    localparam int HW = $clog2(2*H_TOTAL)+1;
    localparam int VW = $clog2(2*V_TOTAL)+1;

    logic          hsync;
    logic          vsync;
    logic          locked;
    logic          line_start;
    logic          frame_start;
    logic          frame_err;
    logic          timeout;
    logic [HW-1:0] h_total_meas;
    logic [HW-1:0] h_sync_meas;
    logic [VW-1:0] v_total_meas;
    logic [VW-1:0] v_sync_meas;
    logic [15:0]   err_count;

    modport master (
        output hsync, vsync,
        input  locked, line_start, frame_start, frame_err, timeout,
        input  h_total_meas, h_sync_meas, v_total_meas, v_sync_meas, err_count
    );

    modport slave (
        input  hsync, vsync,
        output locked, line_start, frame_start, frame_err, timeout,
        output h_total_meas, h_sync_meas, v_total_meas, v_sync_meas, err_count
    );
endinterface

`default_nettype wire

// File: rtl/vga_sync_monitor.sv
// +------------------------------------------------------------------+
// | vga_sync_monitor                                                 |
// | Recovers line/frame timing from hsync/vsync and declares lock.   |
// | Optional error counter: define SYNC_MON_ERR_COUNT_EN.            |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module vga_sync_monitor #(
    parameter int   H_TOTAL         = 800,
    parameter int   HSYNC_WIDTH     = 96,
    parameter int   V_TOTAL         = 525,
    parameter int   VSYNC_WIDTH     = 2,
    parameter int   LOCK_FRAMES     = 3,
    parameter logic SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic              clk_in,
    input  logic              reset,
    vga_sync_monitor_if.slave mon
);
    localparam int HW = $clog2(2*H_TOTAL)+1;
    localparam int VW = $clog2(2*V_TOTAL)+1;
    localparam int GW = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES+1);

    localparam logic          c_ACT_LVL   = ~SYNC_ACTIVE_LOW;
    localparam logic [HW-1:0] c_H_MAX     = {HW{1'b1}};
    localparam logic [VW-1:0] c_V_MAX     = {VW{1'b1}};
    localparam logic [HW-1:0] c_H_TOTAL   = HW'(H_TOTAL);
    localparam logic [HW-1:0] c_HS_WIDTH  = HW'(HSYNC_WIDTH);
    localparam logic [VW-1:0] c_V_TOTAL   = VW'(V_TOTAL);
    localparam logic [VW-1:0] c_VS_WIDTH  = VW'(VSYNC_WIDTH);
    localparam logic [HW-1:0] c_TO_LAST   = HW'(2*H_TOTAL-1);
    localparam logic [GW-1:0] c_LOCK_LAST = GW'(LOCK_FRAMES-1);
    localparam logic [GW-1:0] c_LOCK_CNT  = GW'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    logic          r_hs, r_vs;
    logic          r_line_start, r_frame_start, r_frame_err, r_locked, r_timeout;
    logic [HW-1:0] r_h_cnt, r_h_wid, r_h_total_meas, r_h_sync_meas;
    logic [VW-1:0] r_lines, r_v_wid, r_v_total_meas, r_v_sync_meas;
    logic          r_line_err;
    state_t        r_state, w_state_nxt;
    logic [GW-1:0] r_good_cnt, w_good_nxt;
    logic          w_ferr_nxt;

    logic          w_hs_act, w_vs_act, w_h_rise, w_h_fall, w_v_rise, w_v_fall;
    logic [HW-1:0] w_h_total;
    logic [VW-1:0] w_v_total;
    logic          w_line_bad, w_frame_good, w_to_hit;

    assign w_hs_act = (mon.hsync == c_ACT_LVL);
    assign w_vs_act = (mon.vsync == c_ACT_LVL);
    assign w_h_rise = w_hs_act  && (r_hs != c_ACT_LVL);
    assign w_h_fall = !w_hs_act && (r_hs == c_ACT_LVL);
    assign w_v_rise = w_vs_act  && (r_vs != c_ACT_LVL);
    assign w_v_fall = !w_vs_act && (r_vs == c_ACT_LVL);

    assign w_h_total = (r_h_cnt == c_H_MAX) ? c_H_MAX : r_h_cnt + 1'b1;
    // An hsync edge coinciding with the vsync edge closes the ending frame.
    assign w_v_total = (w_h_rise && (r_lines != c_V_MAX)) ? r_lines + 1'b1 : r_lines;

    assign w_line_bad   = w_h_rise && ((w_h_total != c_H_TOTAL) || (r_h_sync_meas != c_HS_WIDTH));
    assign w_frame_good = !(r_line_err || w_line_bad) && (w_v_total == c_V_TOTAL)
                          && (r_v_sync_meas == c_VS_WIDTH);
    assign w_to_hit     = !w_h_rise && (r_h_cnt == c_TO_LAST);

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_hs           <= ~c_ACT_LVL;
            r_vs           <= ~c_ACT_LVL;
            r_line_start   <= 1'b0;
            r_frame_start  <= 1'b0;
            r_h_cnt        <= '0;
            r_h_wid        <= '0;
            r_h_total_meas <= '0;
            r_h_sync_meas  <= '0;
            r_lines        <= '0;
            r_v_wid        <= '0;
            r_v_total_meas <= '0;
            r_v_sync_meas  <= '0;
            r_line_err     <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            r_hs          <= mon.hsync;
            r_vs          <= mon.vsync;
            r_line_start  <= w_h_rise;
            r_frame_start <= w_v_rise;

            if (w_h_rise) begin
                r_h_cnt        <= '0;
                r_h_total_meas <= w_h_total;
            end else if (r_h_cnt != c_H_MAX) begin
                r_h_cnt <= r_h_cnt + 1'b1;
            end

            if (w_h_rise)
                r_h_wid <= HW'(1);
            else if (w_hs_act && (r_h_wid != c_H_MAX))
                r_h_wid <= r_h_wid + 1'b1;
            if (w_h_fall)
                r_h_sync_meas <= r_h_wid;

            if (w_v_rise) begin
                r_v_total_meas <= w_v_total;
                r_lines        <= '0;
            end else if (w_h_rise && (r_lines != c_V_MAX)) begin
                r_lines <= r_lines + 1'b1;
            end

            if (w_v_rise)
                r_v_wid <= w_h_rise ? VW'(1) : '0;
            else if (w_vs_act && w_h_rise && (r_v_wid != c_V_MAX))
                r_v_wid <= r_v_wid + 1'b1;
            if (w_v_fall)
                r_v_sync_meas <= r_v_wid;

            if (w_v_rise)
                r_line_err <= 1'b0;
            else if (w_line_bad)
                r_line_err <= 1'b1;

            if (w_h_rise)
                r_timeout <= 1'b0;
            else if (w_to_hit)
                r_timeout <= 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_state     <= ST_SEARCH;
            r_good_cnt  <= '0;
            r_locked    <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_good_cnt  <= w_good_nxt;
            r_locked    <= (w_state_nxt == ST_LOCKED);
            r_frame_err <= w_ferr_nxt;
        end
    end

    // Timeout overrides any frame decision made in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good_cnt;
        w_ferr_nxt  = 1'b0;
        if (w_to_hit) begin
            w_state_nxt = ST_SEARCH;
            w_good_nxt  = '0;
        end else if (w_v_rise) begin
            case (r_state)
                ST_SEARCH: begin
                    w_state_nxt = ST_CHECK;
                    w_good_nxt  = '0;
                end
                ST_CHECK: begin
                    if (!w_frame_good) begin
                        w_good_nxt = '0;
                        w_ferr_nxt = 1'b1;
                    end else if (r_good_cnt == c_LOCK_LAST) begin
                        w_state_nxt = ST_LOCKED;
                        w_good_nxt  = c_LOCK_CNT;
                    end else begin
                        w_good_nxt = r_good_cnt + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (!w_frame_good) begin
                        w_state_nxt = ST_CHECK;
                        w_good_nxt  = '0;
                        w_ferr_nxt  = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_SEARCH;
                    w_good_nxt  = '0;
                end
            endcase
        end
    end

`ifdef SYNC_MON_ERR_COUNT_EN
    logic [15:0] r_err_count;

    // w_to_hit is exactly the timeout rising edge: the flag only clears on an hsync edge.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset)
            r_err_count <= '0;
        else if ((w_ferr_nxt || w_to_hit) && (r_err_count != 16'hFFFF))
            r_err_count <= r_err_count + 16'd1;
    end

    assign mon.err_count = r_err_count;
`else
    assign mon.err_count = 16'h0000;
`endif

    assign mon.locked       = r_locked;
    assign mon.line_start   = r_line_start;
    assign mon.frame_start  = r_frame_start;
    assign mon.frame_err    = r_frame_err;
    assign mon.timeout      = r_timeout;
    assign mon.h_total_meas = r_h_total_meas;
    assign mon.h_sync_meas  = r_h_sync_meas;
    assign mon.v_total_meas = r_v_total_meas;
    assign mon.v_sync_meas  = r_v_sync_meas;

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_monitor.sv
// +------------------------------------------------------------------+
// | tb_vga_sync_monitor                                              |
// | Directed bench for vga_sync_monitor on a reduced 20/4/10/2 raster.|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_vga_sync_monitor;
    localparam int H   = 20;
    localparam int HS  = 4;
    localparam int V   = 10;
    localparam int VS  = 2;
    localparam int LCK = 3;

    logic clk;
    logic rst;

    vga_sync_monitor_if #(.H_TOTAL(H), .V_TOTAL(V)) mon ();

    vga_sync_monitor #(
        .H_TOTAL(H), .HSYNC_WIDTH(HS), .V_TOTAL(V), .VSYNC_WIDTH(VS),
        .LOCK_FRAMES(LCK), .SYNC_ACTIVE_LOW(1'b1)
    ) dut (
        .clk_in(clk),
        .reset (rst),
        .mon   (mon)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int cyc = 0, ls_cnt = 0, fs_cnt = 0, fe_cnt = 0;
    int last_ls_cyc = 0, to_cyc = 0, lock_fs = -1;
    bit lock_seen = 1'b0, to_q = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (mon.line_start === 1'b1) begin
            ls_cnt      = ls_cnt + 1;
            last_ls_cyc = cyc;
        end
        if (mon.frame_start === 1'b1) fs_cnt = fs_cnt + 1;
        if (mon.frame_err === 1'b1)   fe_cnt = fe_cnt + 1;
        if (mon.locked === 1'b1 && !lock_seen) begin
            lock_seen = 1'b1;
            lock_fs   = fs_cnt;
        end
        if (mon.timeout === 1'b1 && !to_q) to_cyc = cyc;
        to_q = (mon.timeout === 1'b1);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Active-low syncs; vsync changes together with the hsync assertion.
    task automatic drive_line(input int len, input bit vs_act);
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            mon.hsync = (c < HS) ? 1'b0 : 1'b1;
            mon.vsync = vs_act ? 1'b0 : 1'b1;
        end
    endtask

    task automatic drive_frame(input int vs_w, input int long_line, input int from, input int to);
        for (int l = from; l < to; l++)
            drive_line((l == long_line) ? H + 1 : H, l < vs_w);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_locked"}, {31'd0, mon.locked},      32'd0);
        check_val({tag, "_ls"},     {31'd0, mon.line_start},  32'd0);
        check_val({tag, "_fs"},     {31'd0, mon.frame_start}, 32'd0);
        check_val({tag, "_ferr"},   {31'd0, mon.frame_err},   32'd0);
        check_val({tag, "_to"},     {31'd0, mon.timeout},     32'd0);
        check_val({tag, "_htot"},   32'(mon.h_total_meas),    32'd0);
        check_val({tag, "_hsw"},    32'(mon.h_sync_meas),     32'd0);
        check_val({tag, "_vtot"},   32'(mon.v_total_meas),    32'd0);
        check_val({tag, "_vsw"},    32'(mon.v_sync_meas),     32'd0);
        check_val({tag, "_errc"},   32'(mon.err_count),       32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int ls_base, fs_base, fe_base, exp_err;
        rst = 1'b1;
        mon.hsync = 1'b1;
        mon.vsync = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("rst");
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_val("idle_ls", ls_cnt, 0);
        check_val("idle_fs", fs_cnt, 0);

        // 1 partial + 3 good frames
        for (int f = 0; f < 4; f++) drive_frame(VS, -1, 0, V);
        check_val("lock_locked", {31'd0, mon.locked}, 1);
        check_val("lock_at_fs",  lock_fs, 4);
        check_val("lock_htot",   32'(mon.h_total_meas), H);
        check_val("lock_hsw",    32'(mon.h_sync_meas),  HS);
        check_val("lock_vtot",   32'(mon.v_total_meas), V);
        check_val("lock_vsw",    32'(mon.v_sync_meas),  VS);
        check_val("lock_ferr",   fe_cnt, 0);

        // One 21-clock line
        drive_frame(VS, 5, 0, 7);
        check_val("long_htot", 32'(mon.h_total_meas), H + 1);
        drive_frame(VS, 5, 7, V);
        drive_frame(VS, -1, 0, V);
        check_val("long_ferr",   fe_cnt, 1);
        check_val("long_locked", {31'd0, mon.locked}, 0);
        for (int f = 0; f < 2; f++) drive_frame(VS, -1, 0, V);
        check_val("long_relock2", {31'd0, mon.locked}, 0);
        drive_frame(VS, -1, 0, V);
        check_val("long_relock3", {31'd0, mon.locked}, 1);
        check_val("long_ferr_once", fe_cnt, 1);

        // Three-line vsync for one frame
        drive_frame(3, -1, 0, V);
        drive_frame(VS, -1, 0, 2);
        check_val("vs3_vsw",    32'(mon.v_sync_meas), 3);
        check_val("vs3_vtot",   32'(mon.v_total_meas), V);
        check_val("vs3_ferr",   fe_cnt, 2);
        check_val("vs3_locked", {31'd0, mon.locked}, 0);
        drive_frame(VS, -1, 2, V);
        for (int f = 0; f < 2; f++) drive_frame(VS, -1, 0, V);
        check_val("vs3_relock2", {31'd0, mon.locked}, 0);
        drive_frame(VS, -1, 0, V);
        check_val("vs3_relock3", {31'd0, mon.locked}, 1);

        // Sync stops while locked
        repeat (60) @(negedge clk);
        check_val("to_level",  {31'd0, mon.timeout}, 1);
        check_val("to_locked", {31'd0, mon.locked}, 0);
        check_val("to_delay",  to_cyc - last_ls_cyc, 2 * H);
        check_val("to_htot_kept", 32'(mon.h_total_meas), H);
        check_val("to_vtot_kept", 32'(mon.v_total_meas), V);
        drive_frame(VS, -1, 0, 1);
        check_val("to_cleared", {31'd0, mon.timeout}, 0);
        drive_frame(VS, -1, 1, V);
        for (int f = 0; f < 2; f++) drive_frame(VS, -1, 0, V);
        check_val("to_relock3", {31'd0, mon.locked}, 0);
        drive_frame(VS, -1, 0, V);
        check_val("to_relock4", {31'd0, mon.locked}, 1);

        // Asynchronous reset mid-frame
        drive_frame(VS, -1, 0, 5);
        #2;
        rst = 1'b1;
        mon.hsync = 1'b1;
        mon.vsync = 1'b1;
        #1;
        check_all_zero("arst");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        ls_base = ls_cnt;
        fs_base = fs_cnt;
        fe_base = fe_cnt;
        repeat (8) @(negedge clk);
        check_val("rel_ls", ls_cnt - ls_base, 0);
        check_val("rel_fs", fs_cnt - fs_base, 0);

        // Five bad frames
        drive_frame(VS, -1, 0, V);
        for (int f = 0; f < 5; f++) drive_frame(3, -1, 0, V);
        drive_frame(VS, -1, 0, 1);
        check_val("bad5_ferr", fe_cnt - fe_base, 5);
`ifdef SYNC_MON_ERR_COUNT_EN
        exp_err = 5;
`else
        exp_err = 0;
`endif
        check_val("bad5_errc", 32'(mon.err_count), exp_err);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/vga_sync_monitor.md
Name: vga_sync_monitor

Overview:
- Receive-side counterpart of the VGA timing generators: observes hsync/vsync and recovers line/frame timing.
- Measures total and sync widths, checks them against expected timing and declares lock after consecutive good frames.
- Used for self-check of the timing chain and for loopback verification on the Basys board; lives beside the timing blocks in rtl/timing.
- The hsync/vsync inputs are synchronous to clk_in; no CDC inside.

Parameters:
- H_TOTAL, 800, expected clocks per line.
- HSYNC_WIDTH, 96, expected hsync active width in clocks.
- V_TOTAL, 525, expected lines per frame.
- VSYNC_WIDTH, 2, expected vsync active width in lines.
- LOCK_FRAMES, 3, consecutive good frames required to assert locked.
- SYNC_ACTIVE_LOW, 1'b1, polarity of both sync inputs; 1 means active level is 0.

Ports:
- clk_in  input  1  pixel clock.
- reset  input  1  asynchronous, active-high reset.
- hsync  input  1  horizontal sync.
- vsync  input  1  vertical sync.
- locked  output  1  timing matches expected.
- line_start  output  1  one-cycle pulse on the hsync assertion edge.
- frame_start  output  1  one-cycle pulse on the vsync assertion edge.
- frame_err  output  1  one-cycle pulse when a frame fails the check.
- timeout  output  1  level; no hsync edge seen within 2*H_TOTAL clocks.
- h_total_meas  output  HW  last measured clocks per line. HW = $clog2(2*H_TOTAL)+1.
- h_sync_meas  output  HW  last measured hsync width in clocks.
- v_total_meas  output  VW  last measured lines per frame. VW = $clog2(2*V_TOTAL)+1.
- v_sync_meas  output  VW  last measured vsync width in lines.
- err_count  output  16  frame error counter; see Optional Feature.

Behaviour:
- Reset: all outputs 0; FSM in SEARCH; internal counters 0.
- Sync input registers reset to the inactive level, so reset release produces no spurious edge.
- Edge detect: one register stage per sync input. The assertion edge is the transition to the active level; the deassertion edge is the transition away from it. line_start and frame_start assert the cycle after the input transition.
- h counter: +1 per clock, saturating at all-ones.
  - On the hsync assertion edge: h_total_meas <= h_cnt+1, then h_cnt <= 0.
  - The width counter counts clocks while hsync is active; on the deassertion edge it latches into h_sync_meas.
- Line counter: +1 per hsync assertion edge, saturating.
  - On the vsync assertion edge: v_total_meas <= lines, then lines <= 0.
  - If hsync and vsync assertion edges occur in the same cycle, that hsync edge counts toward the ending frame (the latched value includes it).
  - vsync width = hsync assertion edges while vsync is active; latched into v_sync_meas on the vsync deassertion edge.
- line_err sticky flag: set on any hsync assertion edge where h_total ≠ H_TOTAL or the previous h_sync_meas ≠ HSYNC_WIDTH. Cleared at each frame boundary.
- Frame check at the vsync assertion edge: good = !line_err && v_total == V_TOTAL && v_sync_meas == VSYNC_WIDTH.
- FSM:
  - SEARCH: first vsync assertion edge → CHECK, good_cnt=0. That first frame is partial and is not judged.
  - CHECK: good → good_cnt++; when good_cnt reaches LOCK_FRAMES → LOCKED, locked=1 the same cycle as the transition. Bad → good_cnt=0, frame_err pulse, stay in CHECK.
  - LOCKED: bad → frame_err pulse, locked=0, CHECK with good_cnt=0.
- Timeout: the clocks-since-hsync-edge counter reaching 2*H_TOTAL sets timeout=1, locked=0, FSM → SEARCH. The next hsync edge clears timeout.
- Measurement registers keep their last values across timeout and unlock.
- A reset asserted mid-frame returns everything to reset values asynchronously.

Optional Feature:
- Macro: SYNC_MON_ERR_COUNT_EN.
- Defined: err_count increments on every frame_err pulse and on each timeout rising edge; it saturates at 16'hFFFF and clears only on reset.
- Undefined: err_count is tied to 0 and no counter logic is synthesized.

Test Plan:
- Drive clean 800/96/525/2 active-low sync (use the vsync generator plus a matching hsync model) → locked rises on the 4th vsync assertion edge after reset (1 partial + 3 good); measurements read 800/96/525/2.
- Once locked, stretch one line to 801 clocks → frame_err pulses once at the next vsync edge; locked drops; locked is regained after 3 more clean frames.
- Set vsync width to 3 lines for one frame → v_sync_meas=3, frame_err pulses, good_cnt restarts.
- Stop hsync while locked → timeout=1 and locked=0 exactly 1600 clocks after the last hsync edge; resuming sync clears timeout; relock after 1+3 frames.
- Assert reset mid-frame while locked → all outputs 0 immediately; no line_start/frame_start pulse on release when sync is inactive.
- With SYNC_MON_ERR_COUNT_EN defined, inject 5 bad frames → err_count=5; with it undefined, err_count stays 0.
